// File: rtl/cam_gen.sv
// cam_gen: synthetic OV7670-style camera source producing one RGB444 frame
//   per start request (VSYNC, HREF, two bytes per pixel).
// Latency: start sampled at an edge gives VSYNC/busy high from that same edge.
// Backpressure: none; the bus free-runs once a frame starts, like a real sensor.
//
// Ports:
//   CAM_pclk     pixel clock, all logic on posedge
//   rst          synchronous active-low reset (immediate abort, even mid-line)
//   start        level; sampled in IDLE and in the last VFRONT cycle
//   mode[1:0]    pattern select, latched at frame start
//   color[11:0]  solid colour {R,G,B} for mode 0, latched at frame start
//   CAM_vsync    frame sync, active high
//   CAM_href     line valid, active high
//   CAM_px_data  pixel byte, 0 whenever CAM_href is low
//   busy         high from frame start to frame end
//   frame_done   one-cycle pulse during the last cycle of the front porch
//
// Optional feature macro: CAM_GEN_ANIM_EN adds a 4-bit frame counter that is
// added (mod 16) to the R nibble of every pixel, so successive frames move.
module cam_gen #(
  parameter int H_PIX     = 160,
  parameter int V_LINES   = 120,
  parameter int H_BLANK   = 16,
  parameter int VSYNC_LEN = 3,
  parameter int V_BACK    = 2,
  parameter int V_FRONT   = 2
) (
  input  logic        CAM_pclk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [11:0] color,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic [7:0]  CAM_px_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int LINE_LEN = 2 * H_PIX + H_BLANK;
  localparam int CW       = $clog2(LINE_LEN);
  localparam int LMAX_A   = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
  localparam int LMAX_B   = (V_LINES > V_FRONT) ? V_LINES : V_FRONT;
  localparam int LMAX     = (LMAX_A > LMAX_B) ? LMAX_A : LMAX_B;
  localparam int LW       = $clog2(LMAX + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
  localparam logic [CW-1:0] COL_HREF = CW'(2 * H_PIX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t       st_q, st_nxt;
  logic [CW-1:0] col_q, col_nxt;
  logic [LW-1:0] line_q, line_nxt;
  logic [1:0]   mode_q, mode_nxt;
  logic [11:0]  color_q, color_nxt;
  logic         frame_end;

  // Index of the last line of each counted state.
  function automatic logic [LW-1:0] last_line(input state_t s);
    case (s)
      S_VSYNC:  return LW'(VSYNC_LEN - 1);
      S_VBACK:  return LW'(V_BACK - 1);
      S_ACTIVE: return LW'(V_LINES - 1);
      S_VFRONT: return LW'(V_FRONT - 1);
      default:  return '0;
    endcase
  endfunction

  // Next-state and counter logic. Outputs are derived from these next values
  // and then registered, so every output lines up with the state it belongs to.
  always_comb begin
    st_nxt    = st_q;
    col_nxt   = col_q;
    line_nxt  = line_q;
    mode_nxt  = mode_q;
    color_nxt = color_q;
    frame_end = 1'b0;
    if (st_q == S_IDLE) begin
      if (start) begin
        st_nxt    = S_VSYNC;
        col_nxt   = '0;
        line_nxt  = '0;
        mode_nxt  = mode;
        color_nxt = color;
      end
    end else if (col_q != COL_LAST) begin
      col_nxt = col_q + 1'b1;
    end else begin
      col_nxt = '0;
      if (line_q != last_line(st_q)) begin
        line_nxt = line_q + 1'b1;
      end else begin
        line_nxt = '0;
        case (st_q)
          S_VSYNC:  st_nxt = S_VBACK;
          S_VBACK:  st_nxt = S_ACTIVE;
          S_ACTIVE: st_nxt = S_VFRONT;
          S_VFRONT: begin
            frame_end = 1'b1;
            if (start) begin
              // Back-to-back frame: controls are re-latched here too.
              st_nxt    = S_VSYNC;
              mode_nxt  = mode;
              color_nxt = color;
            end else begin
              st_nxt = S_IDLE;
            end
          end
          default:  st_nxt = S_IDLE;
        endcase
      end
    end
  end

`ifdef CAM_GEN_ANIM_EN
  logic [3:0] anim_q;
  always_ff @(posedge CAM_pclk) begin
    if (!rst) begin
      anim_q <= 4'h0;
    end else if (frame_end) begin
      anim_q <= anim_q + 4'h1;
    end
  end
`endif

  // Pixel generation for the upcoming cycle.
  logic [14:0] px_x, px_y;
  logic [11:0] idx_lo;
  logic [16:0] x4;
  logic [3:0]  r, g, b, r_out;
  logic        href_nxt, vsync_nxt, done_nxt;
  logic [7:0]  data_nxt;

  always_comb begin
    px_x   = 15'(col_nxt >> 1);
    px_y   = 15'(line_nxt);
    // Full linear index is 15 bits; mode 3 only shows its low 12 bits.
    idx_lo = 12'(px_y * 15'(H_PIX) + px_x);
    x4     = {px_x, 2'b00};
    r = 4'h0;
    g = 4'h0;
    b = 4'h0;
    case (mode_nxt)
      2'd0: {r, g, b} = color_nxt;
      2'd1: begin
        r = px_x[3:0];
        g = px_y[3:0];
        b = px_x[7:4];
      end
      2'd2: begin
        // Quadrant = x*4/H_PIX, done as compares against multiples of H_PIX.
        if (x4 < 17'(H_PIX))          {r, g, b} = 12'hF00;
        else if (x4 < 17'(2 * H_PIX)) {r, g, b} = 12'h0F0;
        else if (x4 < 17'(3 * H_PIX)) {r, g, b} = 12'h00F;
        else                          {r, g, b} = 12'hFFF;
      end
      default: {r, g, b} = idx_lo;
    endcase
`ifdef CAM_GEN_ANIM_EN
    r_out = r + anim_q;
`else
    r_out = r;
`endif
    vsync_nxt = (st_nxt == S_VSYNC);
    href_nxt  = (st_nxt == S_ACTIVE) && (col_nxt < COL_HREF);
    data_nxt  = 8'h00;
    if (href_nxt) begin
      data_nxt = col_nxt[0] ? {g, b} : {4'h0, r_out};
    end
    done_nxt = (st_nxt == S_VFRONT) && (col_nxt == COL_LAST) &&
               (line_nxt == last_line(S_VFRONT));
  end

  always_ff @(posedge CAM_pclk) begin
    if (!rst) begin
      st_q        <= S_IDLE;
      col_q       <= '0;
      line_q      <= '0;
      mode_q      <= 2'd0;
      color_q     <= 12'h000;
      CAM_vsync   <= 1'b0;
      CAM_href    <= 1'b0;
      CAM_px_data <= 8'h00;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      st_q        <= st_nxt;
      col_q       <= col_nxt;
      line_q      <= line_nxt;
      mode_q      <= mode_nxt;
      color_q     <= color_nxt;
      CAM_vsync   <= vsync_nxt;
      CAM_href    <= href_nxt;
      CAM_px_data <= data_nxt;
      busy        <= (st_nxt != S_IDLE);
      frame_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_cam_gen.sv
// tb_cam_gen: directed bench for cam_gen using a reduced frame geometry.
// Outputs are sampled on the falling edge; inputs are changed right after.
// Each frame is compared cycle by cycle against a time-indexed frame model.
module tb_cam_gen;

  localparam int H  = 20;
  localparam int VL = 6;
  localparam int HB = 4;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int VF = 2;
  localparam int LL = 2 * H + HB;              // 44
  localparam int FR = (VS + VB + VL + VF) * LL; // 484

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [11:0] color;
  logic        CAM_vsync;
  logic        CAM_href;
  logic [7:0]  CAM_px_data;
  logic        busy;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] cap_dat [FR];
  logic       cap_vs  [FR];
  logic       cap_hr  [FR];
  logic       cap_fd  [FR];

  cam_gen #(
    .H_PIX(H), .V_LINES(VL), .H_BLANK(HB),
    .VSYNC_LEN(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .CAM_pclk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .color(color),
    .CAM_vsync(CAM_vsync),
    .CAM_href(CAM_href),
    .CAM_px_data(CAM_px_data),
    .busy(busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {busy, frame_done, CAM_vsync, CAM_href, CAM_px_data};
  endfunction

  // Expected {busy, frame_done, vsync, href, data} at cycle t of a frame.
  function automatic logic [11:0] model(input int t, input logic [1:0] md,
                                        input logic [11:0] c, input logic [3:0] an);
    int ln, cl, y, x, idx, q;
    logic [3:0] r, g, b;
    logic vs, hr;
    logic [7:0] d;
    ln = t / LL;
    cl = t % LL;
    vs = (ln < VS);
    hr = (ln >= VS + VB) && (ln < VS + VB + VL) && (cl < 2 * H);
    y  = ln - VS - VB;
    x  = cl / 2;
    idx = y * H + x;
    r = 4'h0; g = 4'h0; b = 4'h0;
    case (md)
      2'd0: {r, g, b} = c;
      2'd1: begin r = x[3:0]; g = y[3:0]; b = x[7:4]; end
      2'd2: begin
        q = x * 4 / H;
        case (q)
          0:       {r, g, b} = 12'hF00;
          1:       {r, g, b} = 12'h0F0;
          2:       {r, g, b} = 12'h00F;
          default: {r, g, b} = 12'hFFF;
        endcase
      end
      default: {r, g, b} = idx[11:0];
    endcase
    r = r + an;
    d = 8'h00;
    if (hr) d = (cl % 2 == 0) ? {4'h0, r} : {g, b};
    return {1'b1, (t == FR - 1), vs, hr, d};
  endfunction

  function automatic int tpix(input int x, input int y, input int odd);
    return (VS + VB + y) * LL + 2 * x + odd;
  endfunction

  // Caller has set start=1; the next rising edge begins the frame.
  task automatic run_frame(input string tag, input logic [1:0] md, input logic [11:0] c,
                           input logic [3:0] an, input int chg_t, input logic [1:0] chg_mode,
                           input bit keep_start);
    int bad, first_t;
    logic [11:0] o, e, first_o, first_e;
    bad = 0; first_t = -1; first_o = '0; first_e = '0;
    for (int t = 0; t < FR; t++) begin
      @(negedge clk);
      o = outs();
      e = model(t, md, c, an);
      cap_dat[t] = CAM_px_data;
      cap_vs[t]  = CAM_vsync;
      cap_hr[t]  = CAM_href;
      cap_fd[t]  = frame_done;
      if (o !== e) begin
        if (bad == 0) begin first_t = t; first_o = o; first_e = e; end
        bad++;
      end
      if (t == 0 && !keep_start) start = 1'b0;
      if (t == chg_t) begin mode = chg_mode; color = ~color; end
    end
    checks++;
    assert (bad === 0)
    else begin
      failures++;
      $error("FAIL %s: %0d bad cycles, first t=%0d observed=%h expected=%h",
             tag, bad, first_t, first_o, first_e);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad;
    logic [11:0] o, first_o;
    bad = 0; first_o = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      o = outs();
      if (o !== 12'h000) begin
        if (bad == 0) first_o = o;
        bad++;
      end
    end
    checks++;
    assert (bad === 0)
    else begin
      failures++;
      $error("FAIL %s: %0d non-idle cycles, first observed=%h expected=000", tag, bad, first_o);
    end
  endtask

  initial begin
    int nvs, nhr, nrise, first_hr, nfd, nboth;
    logic [7:0] anim_exp;
    rst = 1'b0; start = 1'b0; mode = 2'd0; color = 12'h000;

    // Reset for two cycles.
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(outs()), 32'h0);
    rst = 1'b1;
    idle_check("idle_after_reset", 5);

    // Single frame, mode 3, start pulsed for one cycle.
    mode = 2'd3; start = 1'b1;
    run_frame("frame_mode3", 2'd3, 12'h000, 4'h0, -1, 2'd0, 1'b0);
    @(negedge clk);
    chk("busy_after_stop", 32'(busy), 32'h0);
    nvs = 0; nhr = 0; nrise = 0; first_hr = -1; nfd = 0; nboth = 0;
    for (int t = 0; t < FR; t++) begin
      if (cap_vs[t]) nvs++;
      if (cap_hr[t]) nhr++;
      if (cap_hr[t] && first_hr < 0) first_hr = t;
      if (cap_hr[t] && (t == 0 || !cap_hr[t-1])) nrise++;
      if (cap_fd[t]) nfd++;
      if (cap_vs[t] && cap_hr[t]) nboth++;
    end
    chk("vsync_cycles", 32'(nvs), 32'd88);
    chk("first_href_t", 32'(first_hr), 32'd132);
    chk("href_cycles", 32'(nhr), 32'd240);
    chk("href_pulses", 32'(nrise), 32'd6);
    chk("frame_done_cnt", 32'(nfd), 32'd1);
    chk("frame_done_pos", 32'(cap_fd[FR-1]), 32'd1);
    chk("vsync_href_overlap", 32'(nboth), 32'd0);
    chk("m3_last_even", 32'(cap_dat[tpix(19, 5, 0)]), 32'h00);
    chk("m3_last_odd", 32'(cap_dat[tpix(19, 5, 1)]), 32'h77);
    chk("m3_x3y1_odd", 32'(cap_dat[tpix(3, 1, 1)]), 32'h17);
    chk("m3_blank", 32'(cap_dat[tpix(0, 2, 0) - 2]), 32'h00);
    idle_check("idle_between", 40);

    // Solid colour.
    mode = 2'd0; color = 12'h5A3; start = 1'b1;
    run_frame("frame_solid", 2'd0, 12'h5A3, 4'h0, -1, 2'd0, 1'b0);
    chk("solid_even", 32'(cap_dat[tpix(7, 3, 0)]), 32'h05);
    chk("solid_odd", 32'(cap_dat[tpix(7, 3, 1)]), 32'hA3);
    idle_check("idle_after_solid", 10);

    // Continuous: mode 1 -> 2 changed mid-frame during active line 2.
    mode = 2'd1; color = 12'h123; start = 1'b1;
    run_frame("frame_cont_m1", 2'd1, 12'h123, 4'h0, tpix(2, 2, 1), 2'd2, 1'b1);
    chk("m1_y4x17_even", 32'(cap_dat[tpix(17, 4, 0)]), 32'h01);
    chk("m1_y4x17_odd", 32'(cap_dat[tpix(17, 4, 1)]), 32'h41);
    run_frame("frame_cont_m2", 2'd2, 12'h000, 4'h0, -1, 2'd0, 1'b0);
    chk("bar_x0_even", 32'(cap_dat[tpix(0, 0, 0)]), 32'h0F);
    chk("bar_x0_odd", 32'(cap_dat[tpix(0, 0, 1)]), 32'h00);
    chk("bar_x5_odd", 32'(cap_dat[tpix(5, 1, 1)]), 32'hF0);
    chk("bar_x14_odd", 32'(cap_dat[tpix(14, 2, 1)]), 32'h0F);
    chk("bar_x15_even", 32'(cap_dat[tpix(15, 3, 0)]), 32'h0F);
    chk("bar_x15_odd", 32'(cap_dat[tpix(15, 3, 1)]), 32'hFF);
    idle_check("idle_after_cont", 10);

    // Reset mid-line: active line 1, byte 7.
    mode = 2'd3; start = 1'b1;
    for (int t = 0; t <= tpix(3, 1, 1); t++) begin
      @(negedge clk);
      if (t == 0) start = 1'b0;
    end
    chk("pre_abort_href", 32'(CAM_href), 32'h1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 32'(outs()), 32'h0);
    rst = 1'b1;
    idle_check("idle_after_abort", 30);

    // Seventeen back-to-back frames of black; shows the animation offset if enabled.
    mode = 2'd0; color = 12'h000; start = 1'b1;
    for (int f = 0; f < 17; f++) begin
`ifdef CAM_GEN_ANIM_EN
      run_frame($sformatf("frame_anim_%0d", f), 2'd0, 12'h000, 4'(f), -1, 2'd0, f < 16);
      anim_exp = (f == 1) ? 8'h01 : 8'h00;
`else
      run_frame($sformatf("frame_anim_%0d", f), 2'd0, 12'h000, 4'h0, -1, 2'd0, f < 16);
      anim_exp = 8'h00;
`endif
      if (f == 0 || f == 1 || f == 16) begin
        chk($sformatf("anim_f%0d_even", f), 32'(cap_dat[tpix(4, 2, 0)]), 32'(anim_exp));
        chk($sformatf("anim_f%0d_odd", f), 32'(cap_dat[tpix(4, 2, 1)]), 32'h00);
      end
    end
    idle_check("idle_final", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
